cycle_block_cnt: RTL and testbench
==================================

// Module: cycle_block_cnt
// PURPOSE
// - Block-cycle sequencer for the pipelined DNN trainer. One block cycle is CPC clocks and processes one training case.
// - Generates the in-block cycle index and a one-clock block-end pulse.
// - Generates the sub-word select that walks the input and ideal-output muxes.
// - Tracks the training-case index, the epoch and completion.
// PARAMETERS
// - CPC             18     clocks per block cycle; default is n[0]*fo[0]/z[0]+2 = 1024*8/512+2; must be >= 4
// - TRAINING_CASES  10000  cases per epoch; case index wraps after this many
// - EPOCHS          10     epochs before done; total blocks = TRAINING_CASES*EPOCHS
// PORTS
// - clk          in   1                          rising-edge clock
// - reset        in   1                          asynchronous, active-low (0 = reset)
// - count        out  $clog2(CPC)                in-block cycle index, 0..CPC-1
// - cycle_clk    out  1                          high for exactly the clock where count==CPC-1
// - sel_network  out  $clog2(CPC-2)              mux select = count[SW-1:0]-2, modulo 2^SW, where SW=$clog2(CPC-2)
// - out_valid    out  1                          high when count>=2; network output is valid after 2-cycle pipeline delay
// - case_idx     out  $clog2(TRAINING_CASES)     current training-case index
// - epoch        out  $clog2(EPOCHS+1)           completed epochs, 0..EPOCHS
// - done         out  1                          sticky; high once TRAINING_CASES*EPOCHS blocks have completed
// BEHAVIOUR
// - Reset (reset==0, asynchronous) values:
//   - count=0, cycle_clk=0, case_idx=0, epoch=0, done=0.
//   - sel_network=CPC-2-derived value (2^SW-2); out_valid=0.
// - Reset released mid-block restarts the block at count=0; no partial state is kept.
// - Every rising edge with done==0: count <= (count==CPC-1) ? 0 : count+1.
// - cycle_clk is registered: set on the edge that loads count=CPC-1, cleared on the next edge.
//   - It is exactly one clk wide, every CPC clocks.
//   - The first pulse arrives CPC-1 clocks after reset release.
// - sel_network and out_valid are combinational from count.
//   - Wrap is intentional: for CPC=18, count 0,1 -> 14,15; count 2..17 -> 0..15 (low 4 bits).
// - Block end is the edge where count goes CPC-1 -> 0. On that edge:
//   - case_idx <= (case_idx==TRAINING_CASES-1) ? 0 : case_idx+1.
//   - If case_idx wraps, epoch <= epoch+1.
//   - If that wrap makes epoch==EPOCHS, done <= 1.
// - Once done=1: count, case_idx and epoch freeze at their values; cycle_clk stays 0; done holds until reset.
// - Widths: all counters are unsigned and wrap only by explicit compare, never by natural overflow (except the sel_network subtract).
// CONFIGURATION
// - Macro CYCLE_BLOCK_STALL_EN.
// - Defined: adds input port `stall` (1 bit), placed after reset.
//   - stall==1 holds count, case_idx, epoch and done.
//   - Forces cycle_clk to 0 on the next edge.
//   - On stall release, the pulse occurs when count next reaches CPC-1.
// - Undefined: no stall port; the counter free-runs as described above.
// TESTING
// - Params CPC=6, TRAINING_CASES=3, EPOCHS=2 unless stated.
// - Reset: hold reset=0 for 3 clks -> count=0, case_idx=0, epoch=0, done=0, cycle_clk=0.
//   - Assert reset=0 mid-count while clk is stopped -> outputs clear immediately.
// - Free-run: release reset -> count sequence 0,1,2,3,4,5,0; cycle_clk high only while count==5.
//   - out_valid=0 at count 0,1; out_valid=1 at count 2..5.
// - Select: CPC=18 -> sel_network = 14,15,0,1,...,15 for count 0..17.
// - Case/epoch wrap: after 3 block ends -> case_idx 1,2,0, epoch=1.
//   - After 6 block ends -> done=1, and count stays frozen for 20 further clks.
// - Stall (CYCLE_BLOCK_STALL_EN): stall=1 for 4 clks at count=3 -> count stays 3.
//   - Pulse is delayed by 4 clks; case_idx is unchanged during the stall.
// - Defaults: CPC=18, 100000 blocks -> done asserts exactly at clk 1,800,000 after reset release; epoch=10.

Source files
------------

// File: rtl/cycle_block_cnt.sv
// rtl/cycle_block_cnt.sv - block-cycle sequencer: in-block count, block pulse, sub-word select, case/epoch tracking
// Optional feature: define CYCLE_BLOCK_STALL_EN to add the stall input.
module cycle_block_cnt #(
    parameter int CPC            = 18,
    parameter int TRAINING_CASES = 10000,
    parameter int EPOCHS         = 10
) (
    input  logic                              clk,
    input  logic                              reset,
`ifdef CYCLE_BLOCK_STALL_EN
    input  logic                              stall,
`endif
    output logic [$clog2(CPC)-1:0]            count,
    output logic                              cycle_clk,
    output logic [$clog2(CPC-2)-1:0]          sel_network,
    output logic                              out_valid,
    output logic [$clog2(TRAINING_CASES)-1:0] case_idx,
    output logic [$clog2(EPOCHS+1)-1:0]       epoch,
    output logic                              done
);

    localparam int CW = $clog2(CPC);
    localparam int SW = $clog2(CPC-2);
    localparam int KW = $clog2(TRAINING_CASES);
    localparam int EW = $clog2(EPOCHS+1);

    localparam logic [CW-1:0] COUNT_LAST = CW'(CPC-1);
    localparam logic [CW-1:0] COUNT_PRE  = CW'(CPC-2);
    localparam logic [KW-1:0] CASE_LAST  = KW'(TRAINING_CASES-1);
    localparam logic [EW-1:0] EPOCH_LAST = EW'(EPOCHS-1);

    logic hold;
    logic advance;
    logic block_end;
    logic case_wrap;

`ifdef CYCLE_BLOCK_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    assign advance   = !done && !hold;
    assign block_end = advance && (count == COUNT_LAST);
    assign case_wrap = (case_idx == CASE_LAST);

    // The two leading counts of a block wrap to the top select values.
    assign sel_network = count[SW-1:0] - SW'(2);
    assign out_valid   = (count >= CW'(2));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            cycle_clk <= 1'b0;
            case_idx  <= '0;
            epoch     <= '0;
            done      <= 1'b0;
        end else begin
            // Registered pulse: high on the edge that loads the last count.
            cycle_clk <= advance && (count == COUNT_PRE);
            if (advance) begin
                count <= (count == COUNT_LAST) ? '0 : count + 1'b1;
            end
            if (block_end) begin
                case_idx <= case_wrap ? '0 : case_idx + 1'b1;
                if (case_wrap) begin
                    epoch <= epoch + 1'b1;
                    if (epoch == EPOCH_LAST) begin
                        done <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cycle_block_cnt.sv
// tb/tb_cycle_block_cnt.sv - scoreboard bench for cycle_block_cnt (CPC=6/TC=3/EP=2 plus a CPC=18 select instance)
module tb_cycle_block_cnt;

    localparam int CPC = 6;
    localparam int TC  = 3;
    localparam int EP  = 2;

    logic       clk    = 1'b0;
    logic       clk_en = 1'b1;
    logic       reset  = 1'b0;
    logic       stall  = 1'b0;

    logic [2:0] count;
    logic       cycle_clk;
    logic [1:0] sel_network;
    logic       out_valid;
    logic [1:0] case_idx;
    logic [1:0] epoch;
    logic       done;

    logic [4:0]  count18;
    logic        cycle_clk18;
    logic [3:0]  sel18;
    logic        out_valid18;
    logic [13:0] case_idx18;
    logic [3:0]  epoch18;
    logic        done18;

    cycle_block_cnt #(.CPC(CPC), .TRAINING_CASES(TC), .EPOCHS(EP)) dut (
        .clk(clk),
        .reset(reset),
`ifdef CYCLE_BLOCK_STALL_EN
        .stall(stall),
`endif
        .count(count),
        .cycle_clk(cycle_clk),
        .sel_network(sel_network),
        .out_valid(out_valid),
        .case_idx(case_idx),
        .epoch(epoch),
        .done(done)
    );

    cycle_block_cnt #(.CPC(18), .TRAINING_CASES(10000), .EPOCHS(10)) dut18 (
        .clk(clk),
        .reset(reset),
`ifdef CYCLE_BLOCK_STALL_EN
        .stall(1'b0),
`endif
        .count(count18),
        .cycle_clk(cycle_clk18),
        .sel_network(sel18),
        .out_valid(out_valid18),
        .case_idx(case_idx18),
        .epoch(epoch18),
        .done(done18)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    typedef struct {
        int count;
        int cc;
        int sel;
        int ov;
        int cs;
        int ep;
        int dn;
        int count18;
        int sel18;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    int m_count, m_cc, m_case, m_epoch, m_done, m18;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_cc = 0; m_case = 0; m_epoch = 0; m_done = 0; m18 = 0;
    endtask

    task automatic model_edge();
        if (!reset) begin
            model_reset();
        end else begin
            if (!m_done && !stall) begin
                m_cc = (m_count == CPC-2) ? 1 : 0;
                if (m_count == CPC-1) begin
                    m_count = 0;
                    if (m_case == TC-1) begin
                        m_case = 0;
                        m_epoch++;
                        if (m_epoch == EP) m_done = 1;
                    end else begin
                        m_case++;
                    end
                end else begin
                    m_count++;
                end
            end else begin
                m_cc = 0;
            end
            m18 = (m18 == 17) ? 0 : m18 + 1;
        end
    endtask

    task automatic push_expected();
        exp_t e;
        e.count   = m_count;
        e.cc      = m_cc;
        e.sel     = (m_count + 4 - 2) % 4;
        e.ov      = (m_count >= 2) ? 1 : 0;
        e.cs      = m_case;
        e.ep      = m_epoch;
        e.dn      = m_done;
        e.count18 = m18;
        e.sel18   = (m18 + 16 - 2) % 16;
        sb.push_back(e);
    endtask

    task automatic compare_front(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check_val({tag, "_sb_empty"}, 0, 1);
            return;
        end
        e = sb.pop_front();
        check_val({tag, "_count"},     int'(count),       e.count);
        check_val({tag, "_cycle_clk"}, int'(cycle_clk),   e.cc);
        check_val({tag, "_sel"},       int'(sel_network), e.sel);
        check_val({tag, "_out_valid"}, int'(out_valid),   e.ov);
        check_val({tag, "_case_idx"},  int'(case_idx),    e.cs);
        check_val({tag, "_epoch"},     int'(epoch),       e.ep);
        check_val({tag, "_done"},      int'(done),        e.dn);
        check_val({tag, "_count18"},   int'(count18),     e.count18);
        check_val({tag, "_sel18"},     int'(sel18),       e.sel18);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        push_expected();
        #1;
        compare_front(tag);
    endtask

    initial begin
        model_reset();

        // Reset held for three clocks.
        repeat (3) step("reset");

        // Free-run through the first two blocks.
        reset = 1'b1;
        for (int i = 0; i < 2*CPC; i++) step("run");
        check_val("two_blocks_case_idx", int'(case_idx), 2);

        // Run to the third block end (epoch wrap) and on to done.
        for (int i = 0; i < CPC; i++) step("epoch_wrap");
        check_val("epoch_after_3_blocks", int'(epoch), 1);
        for (int i = 0; i < 3*CPC; i++) step("to_done");
        check_val("done_after_6_blocks", int'(done), 1);
        for (int i = 0; i < 20; i++) step("frozen");
        check_val("frozen_count", int'(count), 0);

        // Restart, then assert reset mid-count with the clock stopped.
        reset = 1'b0;
        step("restart_reset");
        reset = 1'b1;
        for (int i = 0; i < 9; i++) step("pre_async");
        clk_en = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        push_expected();
        compare_front("async_reset");
        #2;
        clk_en = 1'b1;
        step("async_hold");
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step("post_async");

`ifdef CYCLE_BLOCK_STALL_EN
        for (int i = 0; i < 2*CPC && m_count != 3; i++) step("seek3");
        check_val("stall_start_count", int'(count), 3);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) step("stall");
        check_val("stall_count_held", int'(count), 3);
        stall = 1'b0;
        for (int i = 0; i < 2*CPC; i++) step("after_stall");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
